// File: rtl/exec_stage_muldiv_pkg.sv
// Package exec_pkg: shared definitions for the execute stage.
//   - ALU / mul-div op codes (5-bit)
//   - iterative mul/div FSM state encoding
//   - is_muldiv(): op code belongs to the multi-cycle unit
package exec_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD    = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 5'd1;
  localparam logic [OP_W-1:0] OP_AND    = 5'd2;
  localparam logic [OP_W-1:0] OP_OR     = 5'd3;
  localparam logic [OP_W-1:0] OP_XOR    = 5'd4;
  localparam logic [OP_W-1:0] OP_SLL    = 5'd5;
  localparam logic [OP_W-1:0] OP_SRL    = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA    = 5'd7;
  localparam logic [OP_W-1:0] OP_SLT    = 5'd8;
  localparam logic [OP_W-1:0] OP_SLTU   = 5'd9;
  localparam logic [OP_W-1:0] OP_MUL    = 5'd10;
  localparam logic [OP_W-1:0] OP_MULH   = 5'd11;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'd12;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'd13;
  localparam logic [OP_W-1:0] OP_DIV    = 5'd14;
  localparam logic [OP_W-1:0] OP_DIVU   = 5'd15;
  localparam logic [OP_W-1:0] OP_REM    = 5'd16;
  localparam logic [OP_W-1:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

endpackage

// File: rtl/exec_stage_muldiv_muldiv_iter.sv
// muldiv_iter: iterative multiply / restoring divide unit.
//   clk, rst_n   clock, async active-low reset
//   start        launch with op/a/b (sampled only in IDLE)
//   kill         abort any operation, return to IDLE
//   ack          consumer took the result (DONE -> IDLE)
//   op, a, b     op code and operands
//   busy         iterating
//   done         result valid, waiting for ack
//   result       registered result
// Signed operations run on operand magnitudes; the sign is applied once
// after the last step.
module muldiv_iter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic            ack,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  md_state_e          state;
  logic [CW-1:0]      cnt;
  logic [OP_W-1:0]    op_q;
  logic               neg_p, neg_q, neg_r;
  logic [2*XLEN-1:0]  acc, mcand;
  logic [XLEN-1:0]    mplier, dmag, rem, quo;

  logic               a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]    ma, mb;
  logic [2*XLEN-1:0]  acc_nx, prod;
  logic [XLEN:0]      r_try, diff;
  logic [XLEN-1:0]    rem_nx, quo_nx, q_f, r_f, final_res;

  always_comb begin
    a_sgn = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa    = a_sgn & a[XLEN-1];
    sb    = b_sgn & b[XLEN-1];
    ma    = sa ? (~a + XLEN'(1)) : a;
    mb    = sb ? (~b + XLEN'(1)) : b;
  end

  // One radix-2^MUL_STEP multiply step and one restoring divide step.
  always_comb begin
    acc_nx = acc + (mcand * {{(2*XLEN-MUL_STEP){1'b0}}, mplier[MUL_STEP-1:0]});
    r_try  = {rem, quo[XLEN-1]};
    diff   = r_try - {1'b0, dmag};
    if (!diff[XLEN]) begin
      rem_nx = diff[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_nx = r_try[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b0};
    end
    prod = neg_p ? (~acc_nx + (2*XLEN)'(1)) : acc_nx;
    q_f  = neg_q ? (~quo_nx + XLEN'(1)) : quo_nx;
    r_f  = neg_r ? (~rem_nx + XLEN'(1)) : rem_nx;
    case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = q_f;
      default:                      final_res = r_f;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      dmag   <= '0;
      rem    <= '0;
      quo    <= '0;
      result <= '0;
    end else if (kill) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state  <= MD_BUSY;
          cnt    <= (op >= OP_DIV) ? CW'(XLEN-1) : CW'(XLEN/MUL_STEP-1);
          op_q   <= op;
          neg_p  <= sa ^ sb;
          // Divide by zero keeps the all-ones quotient unsigned.
          neg_q  <= (sa ^ sb) & (b != '0);
          neg_r  <= sa;
          acc    <= '0;
          mcand  <= {{XLEN{1'b0}}, ma};
          mplier <= mb;
          dmag   <= mb;
          rem    <= '0;
          quo    <= ma;
        end
        MD_BUSY: begin
          acc    <= acc_nx;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          rem    <= rem_nx;
          quo    <= quo_nx;
          if (cnt == '0) begin
            state  <= MD_DONE;
            result <= final_res;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        MD_DONE: if (ack) state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state == MD_BUSY);
  assign done = (state == MD_DONE);

endmodule

// File: rtl/exec_stage_muldiv.sv
// exec_stage_muldiv: execute stage with forwarding, single-cycle ALU,
// iterative mul/div and EX/MEM pipeline registers.
//   mem_stall_i  freeze EX/MEM, block launches
//   flush_i      kill instruction in EX
//   valid_i, rs1/rs2_data_i, imm_i, rs1_i, rs2_i, rd_i, wb_en_i,
//   mem_ctrl_i, alu_op_i, alu_src_i          ID/EX inputs
//   wb_data_i, wb_wen_i, wb_rd_i             MEM/WB forwarding source
//   ex_busy_o                                mul/div occupies the stage
//   valid_o, wb_en_o, mem_ctrl_o, rd_o, result_o, store_data_o  EX/MEM
module exec_stage_muldiv
  import exec_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REGW     = 5,
  parameter int unsigned MUL_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [REGW-1:0] rs1_i,
  input  logic [REGW-1:0] rs2_i,
  input  logic [REGW-1:0] rd_i,
  input  logic            wb_en_i,
  input  logic [1:0]      mem_ctrl_i,
  input  logic [4:0]      alu_op_i,
  input  logic            alu_src_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            wb_wen_i,
  input  logic [REGW-1:0] wb_rd_i,
  output logic            ex_busy_o,
  output logic            valid_o,
  output logic            wb_en_o,
  output logic [1:0]      mem_ctrl_o,
  output logic [REGW-1:0] rd_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] store_data_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] fwd1, fwd2, op2, alu_res, md_result;
  logic            md_busy, md_done, md_idle, launch;
  logic [REGW-1:0] md_rd;
  logic            md_wb_en;
  logic [1:0]      md_mem_ctrl;
  logic [XLEN-1:0] md_store;

  always_comb begin
    if (valid_o && wb_en_o && (rd_o != '0) && (rd_o == rs1_i))        fwd1 = result_o;
    else if (wb_wen_i && (wb_rd_i != '0) && (wb_rd_i == rs1_i))       fwd1 = wb_data_i;
    else                                                              fwd1 = rs1_data_i;
    if (valid_o && wb_en_o && (rd_o != '0) && (rd_o == rs2_i))        fwd2 = result_o;
    else if (wb_wen_i && (wb_rd_i != '0) && (wb_rd_i == rs2_i))       fwd2 = wb_data_i;
    else                                                              fwd2 = rs2_data_i;
    op2 = alu_src_i ? imm_i : fwd2;
  end

  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      OP_ADD:  alu_res = fwd1 + op2;
      OP_SUB:  alu_res = fwd1 - op2;
      OP_AND:  alu_res = fwd1 & op2;
      OP_OR:   alu_res = fwd1 | op2;
      OP_XOR:  alu_res = fwd1 ^ op2;
      OP_SLL:  alu_res = fwd1 << op2[SHW-1:0];
      OP_SRL:  alu_res = fwd1 >> op2[SHW-1:0];
      OP_SRA:  alu_res = $signed(fwd1) >>> op2[SHW-1:0];
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd1) < $signed(op2))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (fwd1 < op2)};
      default: alu_res = '0;
    endcase
  end

  assign md_idle   = !md_busy && !md_done;
  assign launch    = valid_i && is_muldiv(alu_op_i) && !flush_i && !mem_stall_i && md_idle;
  // Drops in the DONE cycle that actually retires, so upstream advances
  // on the same edge the result enters EX/MEM.
  assign ex_busy_o = launch || md_busy || (md_done && mem_stall_i);

  muldiv_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (launch),
    .kill   (flush_i),
    .ack    (!mem_stall_i),
    .op     (alu_op_i),
    .a      (fwd1),
    .b      (op2),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Control and store data captured at launch: forwarding sources change
  // while the unit iterates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_rd       <= '0;
      md_wb_en    <= 1'b0;
      md_mem_ctrl <= '0;
      md_store    <= '0;
    end else if (launch) begin
      md_rd       <= rd_i;
      md_wb_en    <= wb_en_i;
      md_mem_ctrl <= mem_ctrl_i;
      md_store    <= fwd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o      <= 1'b0;
      wb_en_o      <= 1'b0;
      mem_ctrl_o   <= '0;
      rd_o         <= '0;
      result_o     <= '0;
      store_data_o <= '0;
    end else if (!mem_stall_i) begin
      if (flush_i || launch || md_busy) begin
        valid_o    <= 1'b0;
        wb_en_o    <= 1'b0;
        mem_ctrl_o <= '0;
      end else if (md_done) begin
        valid_o      <= 1'b1;
        wb_en_o      <= md_wb_en;
        mem_ctrl_o   <= md_mem_ctrl;
        rd_o         <= md_rd;
        result_o     <= md_result;
        store_data_o <= md_store;
      end else begin
        valid_o      <= valid_i;
        wb_en_o      <= valid_i & wb_en_i;
        mem_ctrl_o   <= valid_i ? mem_ctrl_i : 2'b00;
        rd_o         <= rd_i;
        result_o     <= alu_res;
        store_data_o <= fwd2;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_muldiv.sv
module tb_exec_stage_muldiv;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, mem_stall_i, flush_i, valid_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i, wb_data_i;
  logic [4:0]  rs1_i, rs2_i, rd_i, wb_rd_i, alu_op_i, rd_o;
  logic        wb_en_i, alu_src_i, wb_wen_i;
  logic [1:0]  mem_ctrl_i, mem_ctrl_o;
  logic        ex_busy_o, valid_o, wb_en_o;
  logic [31:0] result_o, store_data_o;

  exec_stage_muldiv #(.XLEN(32), .REGW(5), .MUL_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .wb_en_i(wb_en_i), .mem_ctrl_i(mem_ctrl_i), .alu_op_i(alu_op_i),
    .alu_src_i(alu_src_i), .wb_data_i(wb_data_i), .wb_wen_i(wb_wen_i),
    .wb_rd_i(wb_rd_i), .ex_busy_o(ex_busy_o), .valid_o(valid_o),
    .wb_en_o(wb_en_o), .mem_ctrl_o(mem_ctrl_o), .rd_o(rd_o),
    .result_o(result_o), .store_data_o(store_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
    logic [1:0]  mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic [31:0]        mn;
    mn = 32'h8000_0000;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $signed(a) >>> b[4:0];
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_MUL:  begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      OP_MULH: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
      OP_MULHSU: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
      OP_MULHU: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      OP_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == mn && b == 32'hFFFF_FFFF) return mn;
        return $signed(a) / $signed(b);
      end
      OP_REM:  begin
        if (b == 0) return a;
        if (a == mn && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic src, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd);
    valid_i = 1'b1; alu_op_i = op; rs1_data_i = d1; rs2_data_i = d2; imm_i = imm;
    alu_src_i = src; rs1_i = r1; rs2_i = r2; rd_i = rd; wb_en_i = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_valid"}, {63'b0, valid_o}, 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, {32'b0, result_o}, {32'b0, e.res});
      check({tag, "_rd"}, {59'b0, rd_o}, {59'b0, e.rd});
      check({tag, "_store"}, {32'b0, store_data_o}, {32'b0, e.st});
      check({tag, "_wb_en"}, {63'b0, wb_en_o}, 64'd1);
      check({tag, "_memctl"}, {62'b0, mem_ctrl_o}, {62'b0, e.mc});
    end
  endtask

  // ea/eb: operand values the forwarding network is expected to select.
  task automatic issue(input string tag, input logic [4:0] op, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm, input logic src,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [31:0] ea, input logic [31:0] eb, output int busy_n);
    exp_t e;
    logic acc;
    drive(op, d1, d2, imm, src, r1, r2, rd);
    e.res = model(op, ea, src ? imm : eb);
    e.st  = eb;
    e.rd  = rd;
    e.mc  = mem_ctrl_i;
    exp_q.push_back(e);
    busy_n = 0;
    acc = 1'b0;
    #1;
    for (int c = 0; c < 100 && !acc; c++) begin
      acc = !ex_busy_o;
      if (!acc) busy_n++;
      @(posedge clk); #1;
      if (!acc) check({tag, "_bubble"}, {63'b0, valid_o}, 64'd0);
    end
    if (!acc) check({tag, "_timeout"}, 64'd0, 64'd1);
    valid_i = 1'b0;
    pop_check(tag);
  endtask

  initial begin
    int bn;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; mem_stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    wb_en_i = 1'b0; mem_ctrl_i = '0; alu_op_i = '0; alu_src_i = 1'b0;
    wb_data_i = '0; wb_wen_i = 1'b0; wb_rd_i = '0;
    #12;
    check("rst_valid", {63'b0, valid_o}, 64'd0);
    check("rst_wb_en", {63'b0, wb_en_o}, 64'd0);
    check("rst_memctl", {62'b0, mem_ctrl_o}, 64'd0);
    check("rst_rd", {59'b0, rd_o}, 64'd0);
    check("rst_result", {32'b0, result_o}, 64'd0);
    check("rst_store", {32'b0, store_data_o}, 64'd0);
    check("rst_busy", {63'b0, ex_busy_o}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Forwarding priority
    issue("add_base", OP_ADD, 32'd4, 32'd0, 32'd3, 1'b1, 5'd1, 5'd0, 5'd5, 32'd4, 32'd0, bn);
    wb_wen_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'd9;
    issue("fwd_exmem", OP_ADD, 32'd1, 32'd0, 32'd3, 1'b1, 5'd5, 5'd0, 5'd11, 32'd7, 32'd0, bn);
    wb_rd_i = 5'd6; wb_data_i = 32'd20;
    issue("fwd_memwb", OP_ADD, 32'd1, 32'd0, 32'd3, 1'b1, 5'd6, 5'd0, 5'd12, 32'd20, 32'd0, bn);
    issue("fwd_regfile", OP_ADD, 32'd100, 32'd0, 32'd3, 1'b1, 5'd7, 5'd0, 5'd12, 32'd100, 32'd0, bn);
    wb_wen_i = 1'b0; mem_ctrl_i = 2'b01;
    issue("fwd_store", OP_SUB, 32'd50, 32'd0, 32'd0, 1'b0, 5'd1, 5'd12, 5'd13, 32'd50, 32'd103, bn);
    mem_ctrl_i = 2'b00;

    // ALU boundaries
    issue("sra", OP_SRA, 32'h8000_0000, 32'h21, 32'h0, 1'b0, 5'd1, 5'd2, 5'd14, 32'h8000_0000, 32'h21, bn);
    check("sra_value", {32'b0, result_o}, 64'hC000_0000);
    issue("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd1, 5'd2, 5'd14, 32'd1, 32'hFFFF_FFFF, bn);
    check("sltu_value", {32'b0, result_o}, 64'd1);
    issue("slt", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd1, 5'd2, 5'd14, 32'd1, 32'hFFFF_FFFF, bn);
    check("slt_value", {32'b0, result_o}, 64'd0);
    for (int i = 0; i < 20; i++) begin
      rop = 5'($urandom_range(0, 9)); ra = $urandom; rb = $urandom;
      issue("alu_rand", rop, ra, rb, 32'h0, 1'b0, 5'd1, 5'd2, 5'd20, ra, rb, bn);
    end

    // Mul/div
    issue("mulh", OP_MULH, 32'hFFFF_FFFF, 32'd2, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 32'hFFFF_FFFF, 32'd2, bn);
    check("mulh_value", {32'b0, result_o}, 64'hFFFF_FFFF);
    check("mulh_busy_cycles", 64'(bn), 64'd9);
    issue("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, bn);
    check("div_min_value", {32'b0, result_o}, 64'h8000_0000);
    check("div_busy_cycles", 64'(bn), 64'd33);
    issue("rem_min", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, bn);
    issue("divu_0", OP_DIVU, 32'd7, 32'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 32'd7, 32'd0, bn);
    check("divu_0_value", {32'b0, result_o}, 64'hFFFF_FFFF);
    issue("remu_0", OP_REMU, 32'd7, 32'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 32'd7, 32'd0, bn);
    check("remu_0_value", {32'b0, result_o}, 64'd7);
    issue("div_neg0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 32'hFFFF_FFF9, 32'd0, bn);
    issue("rem_neg0", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 32'hFFFF_FFF9, 32'd0, bn);
    issue("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 32'hFFFF_FFF9, 32'd2, bn);
    issue("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 5'd1, 5'd2, 5'd15, 32'hFFFF_FFF9, 32'd2, bn);
    for (int i = 0; i < 16; i++) begin
      rop = 5'($urandom_range(10, 17)); ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      issue("md_rand", rop, ra, rb, 32'h0, 1'b0, 5'd1, 5'd2, 5'd21, ra, rb, bn);
    end

    // Stall held across DONE
    begin
      exp_t e;
      e.res = 32'd42; e.st = 32'd7; e.rd = 5'd16; e.mc = 2'b00;
      exp_q.push_back(e);
      drive(OP_MUL, 32'd6, 32'd7, 32'h0, 1'b0, 5'd1, 5'd2, 5'd16);
      #1 check("stall_launch_busy", {63'b0, ex_busy_o}, 64'd1);
      @(posedge clk); #1;
      mem_stall_i = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      check("stall_frozen_valid", {63'b0, valid_o}, 64'd0);
      check("stall_done_busy", {63'b0, ex_busy_o}, 64'd1);
      mem_stall_i = 1'b0;
      #1 check("stall_release_busy", {63'b0, ex_busy_o}, 64'd0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      pop_check("stall_mul");
    end

    // Flush: mid-DIV, in the launch cycle, and on a single-cycle op
    drive(OP_DIV, 32'd1000, 32'd3, 32'h0, 1'b0, 5'd1, 5'd2, 5'd17);
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    valid_i = 1'b0; flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    check("flush_mid_busy", {63'b0, ex_busy_o}, 64'd0);
    check("flush_mid_valid", {63'b0, valid_o}, 64'd0);
    issue("after_flush", OP_XOR, 32'hA5A5_0000, 32'h0F0F_F0F0, 32'h0, 1'b0, 5'd1, 5'd2, 5'd18, 32'hA5A5_0000, 32'h0F0F_F0F0, bn);
    drive(OP_DIV, 32'd9, 32'd3, 32'h0, 1'b0, 5'd1, 5'd2, 5'd17);
    flush_i = 1'b1;
    #1 check("flush_launch_busy", {63'b0, ex_busy_o}, 64'd0);
    @(posedge clk); #1;
    check("flush_launch_valid", {63'b0, valid_o}, 64'd0);
    alu_op_i = OP_ADD;
    @(posedge clk); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    check("flush_launch_idle", {63'b0, ex_busy_o}, 64'd0);
    check("flush_add_valid", {63'b0, valid_o}, 64'd0);

    // Reset during BUSY
    issue("pre_reset", OP_OR, 32'h1234_0000, 32'h0000_5678, 32'h0, 1'b0, 5'd1, 5'd2, 5'd19, 32'h1234_0000, 32'h0000_5678, bn);
    drive(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd1, 5'd2, 5'd19);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    valid_i = 1'b0; rst_n = 1'b0;
    #1;
    check("rstmid_valid", {63'b0, valid_o}, 64'd0);
    check("rstmid_wb_en", {63'b0, wb_en_o}, 64'd0);
    check("rstmid_rd", {59'b0, rd_o}, 64'd0);
    check("rstmid_result", {32'b0, result_o}, 64'd0);
    check("rstmid_store", {32'b0, store_data_o}, 64'd0);
    check("rstmid_busy", {63'b0, ex_busy_o}, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rstmid_no_output", {63'b0, valid_o}, 64'd0);
    issue("after_reset", OP_SLL, 32'h0000_0003, 32'h0000_0024, 32'h0, 1'b0, 5'd1, 5'd2, 5'd22, 32'h3, 32'h24, bn);

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
